// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial deserializer (start, LSB-first data, optional even parity, stop)
// with a valid/ready word output and one-cycle parity/framing/overrun pulses.
module serial_frame_rx #(
   parameter int DATA_W    = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_en,
   input  logic              si,
   output logic [DATA_W-1:0] po,
   output logic              po_valid,
   input  logic              po_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] po_q;
   logic [CW-1:0]     cnt_q;
   logic              perr_q;
   logic              po_valid_q;
   logic              parity_err_q;
   logic              frame_err_q;
   logic              overrun_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         po_q         <= '0;
         cnt_q        <= '0;
         perr_q       <= 1'b0;
         po_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         if (po_valid_q && po_ready) po_valid_q <= 1'b0;
         if (bit_en) begin
            case (state_q)
               IDLE: if (!si) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
                  perr_q  <= 1'b0;
               end
               DATA: begin
                  sr_q  <= {si, sr_q[DATA_W-1:1]};
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) state_q <= PARITY_EN ? PARITY : STOP;
               end
               PARITY: begin
                  perr_q  <= ^sr_q ^ si;
                  state_q <= STOP;
               end
               STOP: if (!si) begin
                  frame_err_q <= 1'b1;
                  state_q     <= WAIT_HIGH;
               end else begin
                  state_q <= IDLE;
                  if (perr_q) parity_err_q <= 1'b1;
                  else if (!po_valid_q || po_ready) begin
                     po_q       <= sr_q;
                     po_valid_q <= 1'b1;
                  end else overrun_q <= 1'b1;
               end
               WAIT_HIGH: if (si) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign po         = po_q;
   assign po_valid   = po_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed and randomized frames checked every cycle against a
// frame-level reference model, plus literal checks of the documented scenarios.
module tb_serial_frame_rx;
   localparam int DW = 4;
   localparam int PE = 1;

   logic clk = 1'b0, reset = 1'b0, bit_en = 1'b0, si = 1'b1, po_ready = 1'b1;
   logic [DW-1:0] po;
   logic po_valid, parity_err, frame_err, overrun, busy;
   int n_chk = 0, n_fail = 0;
   int n_pe = 0, n_fe = 0, n_ov = 0;
   bit rnd_ready = 1'b0;

   serial_frame_rx #(.DATA_W(DW), .PARITY_EN(PE)) dut (
      .clk(clk), .reset(reset), .bit_en(bit_en), .si(si), .po(po), .po_valid(po_valid),
      .po_ready(po_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy));

   always #5 clk = ~clk;

   // Reference: k counts strobes sampled since the start bit; brk marks a held-low line.
   int k = 0, ones = 0;
   bit brk = 0, load;
   logic [DW-1:0] word = '0, m_po = '0;
   bit m_valid = 0, m_pe = 0, m_fe = 0, m_ov = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         k = 0; ones = 0; brk = 0; word = '0; m_po = '0;
         m_valid = 0; m_pe = 0; m_fe = 0; m_ov = 0;
      end else begin
         m_pe = 0; m_fe = 0; m_ov = 0; load = 0;
         if (bit_en) begin
            if (brk) begin
               if (si) brk = 0;
            end else if (k == 0) begin
               if (!si) begin k = 1; word = '0; ones = 0; end
            end else if (k <= DW) begin
               word[k-1] = si; ones += int'(si); k++;
            end else if (PE == 1 && k == DW + 1) begin
               ones += int'(si); k++;
            end else begin
               k = 0;
               if (!si) begin m_fe = 1; brk = 1; end
               else if (PE == 1 && (ones % 2) == 1) m_pe = 1;
               else if (m_valid && !po_ready) m_ov = 1;
               else load = 1;
            end
         end
         if (load) begin m_po = word; m_valid = 1; end
         else if (m_valid && po_ready) m_valid = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("po", 32'(po), 32'(m_po));
      chk("po_valid", 32'(po_valid), 32'(m_valid));
      chk("parity_err", 32'(parity_err), 32'(m_pe));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
      chk("overrun", 32'(overrun), 32'(m_ov));
      chk("busy", 32'(busy), 32'((k != 0) || brk));
      if (parity_err === 1'b1) n_pe++;
      if (frame_err === 1'b1) n_fe++;
      if (overrun === 1'b1) n_ov++;
   end

   always @(posedge clk) if (rnd_ready) #1 po_ready = 1'($urandom % 2);

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic strobe(input logic b, input int gap);
      si = b; bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0;
      idle(gap);
   endtask

   task automatic send(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop, input int gap);
      strobe(1'b0, gap);
      for (int i = 0; i < DW; i++) strobe(d[i], gap);
      if (PE == 1) strobe((^d) ^ bad_par, gap);
      strobe(!bad_stop, gap);
   endtask

   task automatic do_reset();
      reset = 1'b1; si = 1'b1; bit_en = 1'b0;
      idle(1);
      reset = 1'b0;
      idle(1);
      n_pe = 0; n_fe = 0; n_ov = 0;
   endtask

   initial begin
      reset = 1'b1;
      #12;
      chk("reset po", 32'(po), 0);
      chk("reset po_valid", 32'(po_valid), 0);
      chk("reset busy", 32'(busy), 0);
      reset = 1'b0;
      idle(1);
      // good frame
      do_reset();
      send(4'hD, 0, 0, 0);
      @(negedge clk);
      chk("good po", 32'(po), 32'hD);
      chk("good valid", 32'(po_valid), 1);
      chk("good busy", 32'(busy), 0);
      @(negedge clk);
      chk("good valid drop", 32'(po_valid), 0);
      idle(1);
      chk("good no errs", 32'(n_pe + n_fe + n_ov), 0);
      // parity error
      do_reset();
      send(4'hD, 1, 0, 0);
      idle(3);
      chk("par pulses", 32'(n_pe), 1);
      chk("par po", 32'(po), 0);
      chk("par valid", 32'(po_valid), 0);
      // framing error, break, then a clean frame
      do_reset();
      send(4'hD, 0, 1, 0);
      repeat (3) strobe(1'b0, 0);
      chk("break busy", 32'(busy), 1);
      strobe(1'b1, 0);
      send(4'h3, 0, 0, 0);
      idle(2);
      chk("brk fe pulses", 32'(n_fe), 1);
      chk("brk pe pulses", 32'(n_pe), 0);
      chk("brk po", 32'(po), 32'h3);
      // overrun
      do_reset();
      po_ready = 1'b0;
      send(4'hD, 0, 0, 0);
      send(4'h6, 0, 0, 0);
      idle(2);
      chk("ovr po", 32'(po), 32'hD);
      chk("ovr valid", 32'(po_valid), 1);
      chk("ovr pulses", 32'(n_ov), 1);
      po_ready = 1'b1;
      idle(1);
      chk("ovr drain", 32'(po_valid), 0);
      // reset mid-frame
      strobe(1'b0, 0); strobe(1'b1, 0); strobe(1'b0, 0);
      reset = 1'b1;
      #1;
      chk("midrst po", 32'(po), 0);
      chk("midrst busy", 32'(busy), 0);
      chk("midrst valid", 32'(po_valid), 0);
      idle(1);
      reset = 1'b0;
      idle(1);
      send(4'hA, 0, 0, 0);
      @(negedge clk);
      chk("after rst po", 32'(po), 32'hA);
      chk("after rst valid", 32'(po_valid), 1);
      idle(1);
      // sparse strobes
      do_reset();
      send(4'hD, 0, 0, 2);
      chk("sparse po", 32'(po), 32'hD);
      chk("sparse errs", 32'(n_pe + n_fe + n_ov), 0);
      // randomized traffic against the model
      rnd_ready = 1'b1;
      for (int f = 0; f < 250; f++) begin
         automatic int gap = int'($urandom % 3);
         automatic bit bp = ($urandom % 8) == 0;
         automatic bit bs = ($urandom % 8) == 0;
         send(DW'($urandom), bp, bs, gap);
         if (bs) begin
            repeat ($urandom % 4) strobe(1'b0, int'($urandom % 2));
            strobe(1'b1, 0);
         end
         if ($urandom % 4 == 0) strobe(1'b1, int'($urandom % 3));
         if ($urandom % 50 == 0) begin
            strobe(1'b0, 0);
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
         end
      end
      rnd_ready = 1'b0;
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver (deserializer) for the 4-bit shift-register link family. It accepts a one-bit-per-strobe line carrying start bit, DATA_W data bits LSB first, optional even parity and stop bit. It reassembles each frame into a parallel word and presents it on a valid/ready output port. Parity, framing and overrun conditions are reported as error pulses. It is the receive end of the serial link whose transmit end is a parallel-in/serial-out shifter.

## Interface
- DATA_W, 4, data bits per frame (≥2)
- PARITY_EN, 1, 1 = even-parity bit follows data; 0 = no parity bit
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- bit_en  in  1  bit strobe; si is sampled only on cycles with bit_en=1
- si  in  1  serial line; idles high
- po  out  DATA_W  received word; bit 0 = first data bit on line
- po_valid  out  1  po holds an unconsumed word
- po_ready  in  1  consumer accepts po when po_valid & po_ready at a rising edge
- parity_err  out  1  one-cycle pulse: parity mismatch, frame dropped
- frame_err  out  1  one-cycle pulse: stop bit sampled low, frame dropped
- overrun  out  1  one-cycle pulse: good frame dropped because po was still held
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Reset values: po=0, po_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. The FSM goes to IDLE and the shift register and bit counter are cleared. Reset mid-frame discards the partial frame.
- Every state holds while bit_en=0. All transitions and samples below occur only on bit_en=1 edges.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: si=0 → DATA and clear the bit counter. si=1 → stay.
- DATA: shift right with the new bit entering the MSB, so sr ← {si, sr[DATA_W-1:1]}. After the DATA_W-th bit, go to PARITY if PARITY_EN=1, otherwise STOP. The bit counter is $clog2(DATA_W+1) wide.
- PARITY: store perr = ^sr ^ si. perr=1 means odd total ones, which is an error. Go to STOP.
- STOP, si=1, perr=1: pulse parity_err, drop the word, → IDLE.
- STOP, si=1, perr=0: good frame, → IDLE.
  - If po_valid=0, or po_valid=1 with po_ready=1 on this same edge: po ← sr, po_valid ← 1.
  - Otherwise pulse overrun. po and po_valid are unchanged and the new word is lost.
- STOP, si=0: pulse frame_err, drop the word, → WAIT_HIGH. frame_err has priority over parity_err; only one error pulse per frame.
- WAIT_HIGH: stay until si=1 is sampled, then → IDLE. A held-low (break) line must not retrigger frames.
- Output handshake is independent of bit_en. On any edge with po_valid & po_ready and no new word loading, po_valid ← 0 and po keeps its value.
- busy = (state != IDLE).

## Timing
- Frame length is 2 + DATA_W + PARITY_EN strobes, from the start-bit sample to the stop-bit sample.
- po/po_valid update on the edge that samples the stop bit and are visible the next cycle. There is no additional pipeline delay.
- Error pulses are registered. They are high for exactly the one cycle following the stop-bit sample edge.
- An edge with po_valid & po_ready completes the transfer. Back-to-back accept and load on the same edge keeps po_valid=1 with the new po.
- bit_en may be a single-cycle strobe at any spacing, including every cycle. Result words must be identical regardless of spacing.
- Minimum legal gap between frames is zero: a stop bit followed immediately by a start bit on the next strobe.

## Test plan
All cases use DATA_W=4 and PARITY_EN=1.
- Good frame: bit_en every cycle, si = 0,1,0,1,1,1,1 (start, data 4'hD LSB first, parity 1, stop), po_ready=1 → po=4'hD, po_valid high for 1 cycle, no error pulses, busy low after stop.
- Parity error: same frame with parity bit 0 → parity_err single pulse, po_valid stays 0, po unchanged (0).
- Framing/break: frame 4'hD with stop bit 0, then si=0 for 3 strobes, then si=1, then frame 4'h3 (0,1,1,0,0,0,1) → one frame_err pulse, no start detected during the low run, then po=4'h3 valid.
- Overrun: po_ready=0, send 4'hD then back-to-back 4'h6 (0,0,1,1,0,0,1) → po=4'hD valid throughout, overrun pulses once. Then po_ready=1 → po_valid drops the next cycle.
- Reset mid-frame: assert reset after start + 2 data bits → all outputs 0 immediately. After release, frame 4'hA (0,0,1,0,1,0,1) → po=4'hA valid.
- Strobe spacing: repeat the good-frame case with bit_en high one cycle in three, si changing only between strobes → po=4'hD, same response, po_valid set on the stop-strobe edge.
